// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: CPU-side memory map responder with an OAM DMA engine.
// Decodes the 16-bit CPU bus into internal RAM, PPU registers, I/O and
// cartridge space, returns registered read data, and runs a 256-byte OAM DMA
// into PPU register 4 while halting the CPU.
//
// Handshake note: there is no valid/ready pairing here. The CPU presents an
// address every cycle and its strobes are single-cycle qualifiers; read data
// is always valid one cycle after the address. The PPU strobes are
// combinational pulses, one per cycle in which they are high, with data valid
// in that same cycle.
module cpu_mem_responder #(
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic [7:0]  cpu_rdata,
    output logic        halt,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_wdata,
    output logic        ppu_write_en,
    output logic        ppu_read_en,
    input  logic [7:0]  ppu_rdata,
    output logic [15:0] cart_addr,
    input  logic [7:0]  cart_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_RD    = 2'd2,
        DMA_WR    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  dma_data_q, dma_data_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        halt_q, halt_d;

    // 2 KB internal RAM; intentionally not cleared by reset
    logic [7:0]  ram_q [0:2047];
    logic        ram_we;

    // CPU-side address decode
    logic        cpu_is_ram;
    logic        cpu_is_ppu;
    logic        cpu_is_io;
    logic        in_idle;
    logic [7:0]  cpu_byte;

    // DMA source address and the byte it decodes to
    logic [15:0] dma_src;
    logic [7:0]  dma_byte;

    assign cpu_is_ram = (cpu_addr[15:13] == 3'b000);
    assign cpu_is_ppu = (cpu_addr[15:13] == 3'b001);
    assign cpu_is_io  = (cpu_addr[15:5] == 11'h200);
    assign in_idle    = (state_q == IDLE);
    assign dma_src    = {page_q, cnt_q};

    // Select the byte the CPU would read at cpu_addr this cycle
    always_comb begin
        cpu_byte = 8'h00;
        if (cpu_is_ram) begin
            cpu_byte = ram_q[cpu_addr[10:0]];
        end else if (cpu_is_ppu) begin
            cpu_byte = ppu_rdata;
        end else if (cpu_is_io) begin
            cpu_byte = 8'h00;
        end else begin
            cpu_byte = cart_rdata;
        end
    end

    // Select the DMA source byte; PPU pages and page 40 read as zero so the
    // DMA never triggers PPU read side effects or touches I/O
    always_comb begin
        dma_byte = 8'h00;
        if (page_q[7:5] == 3'b000) begin
            dma_byte = ram_q[dma_src[10:0]];
        end else if (page_q[7:5] == 3'b001) begin
            dma_byte = 8'h00;
        end else if (page_q == 8'h40) begin
            dma_byte = 8'h00;
        end else begin
            dma_byte = cart_rdata;
        end
    end

    // Next-state logic: CPU access handling in IDLE, DMA sequencing otherwise
    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        cnt_d       = cnt_q;
        dma_data_d  = dma_data_q;
        cpu_rdata_d = cpu_rdata_q;
        halt_d      = halt_q;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_rdata_d = cpu_byte;
                if (cpu_write_en) begin
                    if (cpu_addr == DMA_REG) begin
                        state_d = DMA_ALIGN;
                        page_d  = cpu_wdata;
                        cnt_d   = 8'h00;
                        halt_d  = 1'b1;
                    end else if (cpu_is_ram) begin
                        ram_we = 1'b1;
                    end
                end
            end
            DMA_ALIGN: begin
                state_d = DMA_RD;
            end
            DMA_RD: begin
                dma_data_d = dma_byte;
                state_d    = DMA_WR;
            end
            DMA_WR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = IDLE;
                    halt_d  = 1'b0;
                end else begin
                    state_d = DMA_RD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus-facing combinational outputs; DMA overrides the CPU path
    always_comb begin
        ppu_reg_addr = cpu_addr[2:0];
        ppu_wdata    = cpu_wdata;
        ppu_write_en = in_idle && cpu_write_en && cpu_is_ppu;
        ppu_read_en  = in_idle && cpu_read_en && cpu_is_ppu;
        cart_addr    = cpu_addr;
        if (state_q == DMA_WR) begin
            ppu_reg_addr = 3'd4;
            ppu_wdata    = dma_data_q;
            ppu_write_en = 1'b1;
        end
        if (state_q == DMA_RD) begin
            cart_addr = dma_src;
        end
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            page_q      <= 8'h00;
            cnt_q       <= 8'h00;
            dma_data_q  <= 8'h00;
            cpu_rdata_q <= 8'h00;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            cnt_q       <= cnt_d;
            dma_data_q  <= dma_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            halt_q      <= halt_d;
        end
    end

    // RAM write port; suppressed in a reset cycle
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            ram_q[cpu_addr[10:0]] <= cpu_wdata;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign halt      = halt_q;
    assign dbg_state = state_q;

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 The block SHALL use the signals below, listed as name, direction, width, meaning (clock and reset first).
REQ-002 clk  in  1  single system clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 cpu_addr  in  16  CPU bus address.
REQ-005 cpu_wdata  in  8  CPU write data.
REQ-006 cpu_write_en  in  1  CPU write strobe.
REQ-007 cpu_read_en  in  1  CPU read strobe; gates read side effects only.
REQ-008 cpu_rdata  out  8  registered read data to the CPU.
REQ-009 halt  out  1  registered; stalls the CPU while OAM DMA runs.
REQ-010 ppu_reg_addr  out  3  PPU register index.
REQ-011 ppu_wdata  out  8  PPU write data.
REQ-012 ppu_write_en  out  1  PPU register write strobe.
REQ-013 ppu_read_en  out  1  PPU register read strobe.
REQ-014 ppu_rdata  in  8  PPU register read data, valid in the same cycle.
REQ-015 cart_addr  out  16  cartridge address.
REQ-016 cart_rdata  in  8  cartridge read data, valid in the same cycle.
REQ-017 Parameter DMA_REG, default 16'h4014: address of the OAM DMA trigger register.

Function
REQ-018 Address decode:
- 0000-1FFF: internal 2 KB RAM, indexed by addr[10:0] (mirrored).
- 2000-3FFF: PPU registers, index addr[2:0].
- 4000-401F: I/O; reads return 0.
- 4020-FFFF: cartridge.
REQ-019 cpu_rdata SHALL be re-registered every cycle from the decoded source at cpu_addr, regardless of cpu_read_en, so data is valid one cycle after the address is presented.
REQ-020 A RAM write SHALL occur at the edge ending a cycle with cpu_write_en=1 and an address in 0000-1FFF.
REQ-021 ppu_write_en SHALL be combinational, high when cpu_write_en=1 and cpu_addr is in 2000-3FFF; ppu_wdata=cpu_wdata and ppu_reg_addr=cpu_addr[2:0].
REQ-022 ppu_read_en SHALL be combinational, high when cpu_read_en=1 and cpu_addr is in 2000-3FFF.
REQ-023 Writes to 4000-FFFF other than DMA_REG SHALL be ignored.
REQ-024 FSM states: IDLE, DMA_ALIGN, DMA_RD, DMA_WR.
REQ-025 IDLE -> DMA_ALIGN: when cpu_write_en=1 and cpu_addr=DMA_REG; latch page=cpu_wdata, cnt=0, halt<=1 at that edge.
REQ-026 DMA_ALIGN -> DMA_RD unconditionally after one cycle.
REQ-027 DMA_RD: source address {page,cnt}, decoded per REQ-018; capture the byte into dma_data at the edge; -> DMA_WR.
REQ-028 DMA_RD from a page in 20-3F SHALL capture 0 with no PPU read strobe; from 40 SHALL capture 0.
REQ-029 DMA_WR: ppu_reg_addr=4, ppu_wdata=dma_data, ppu_write_en=1; cnt increments at the edge.
REQ-030 DMA_WR exit: if cnt=255, -> IDLE with halt<=0 (cnt wraps to 0); otherwise -> DMA_RD.
REQ-031 DMA length SHALL be exactly 256 PPU writes; halt SHALL be high for exactly 513 cycles.
REQ-032 While state is not IDLE: CPU writes (including DMA_REG) are dropped; CPU-side PPU strobes are suppressed; cpu_rdata holds its value.
REQ-033 cart_addr SHALL be the DMA source address during DMA_RD and cpu_addr otherwise.
REQ-034 halt SHALL not be affected by cpu_read_en or cpu_write_en outside REQ-025.

Reset
REQ-035 On rst=1 at an edge: state=IDLE, halt=0, cpu_rdata=0, cnt=0, page=0, dma_data=0.
REQ-036 RAM contents are not cleared by reset.
REQ-037 Reset during DMA SHALL abort the transfer; no PPU write occurs in the cycle after the reset edge.
REQ-038 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-039 Write 8'h5A to 16'h0005; read 16'h1805 -> cpu_rdata=8'h5A one cycle after the address is presented.
REQ-040 Write 8'h33 to 16'h2007 -> single-cycle ppu_write_en with ppu_reg_addr=7 and ppu_wdata=8'h33; RAM unchanged.
REQ-041 RAM 0200-02FF preloaded with i^8'hA5; write 8'h02 to 16'h4014 -> halt rises at the next edge and stays high 513 cycles; 256 PPU writes to index 4 carrying A5, A4, ..., 5A in order.
REQ-042 During the REQ-041 DMA, CPU writes 8'hFF to 16'h0000 and 8'h03 to 16'h4014 -> RAM[0] is unchanged and no second DMA starts.
REQ-043 rst asserted after the 100th DMA PPU write -> halt=0 and state=IDLE next cycle; no further PPU writes.
REQ-044 cart_rdata=8'hC3 at cpu_addr 16'h8000 -> cart_addr=16'h8000 and cpu_rdata=8'hC3 one cycle later.
